hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage KGP RISC core; complements the forwarding network for cases forwarding cannot cover.
//  Detects load-use hazards, freezes the pipe while a data-memory access waits, and flushes wrong-path instructions on taken branches.
//  Drives the stage-register write-enables/bubbles for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive MEM_WAIT cycles before abort (1..255)
//  CNT_W        16  width of stall/flush performance counters
// PORTS
//  clk              in   1      core clock, all state on rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  id_rs            in   5      source reg 1 of instruction in ID
//  id_rt            in   5      source reg 2 of instruction in ID
//  id_uses_rt       in   1      ID instruction reads rt
//  id_ex_memread    in   1      instruction in EX is a load
//  id_ex_rd         in   5      destination of instruction in EX
//  ex_branch_taken  in   1      branch/jump in EX resolved taken
//  ex_mem_memreq    in   1      instruction in MEM accesses data memory
//  mem_ready        in   1      data memory completes access this cycle
//  pc_write         out  1      PC register load enable
//  if_id_write      out  1      IF/ID load enable
//  if_id_flush      out  1      IF/ID loads NOP
//  id_ex_bubble     out  1      ID/EX loads NOP (control bits zeroed)
//  ex_mem_write     out  1      ID/EX and EX/MEM load enable
//  mem_wb_bubble    out  1      MEM/WB loads NOP
//  mem_err          out  1      sticky: memory timeout occurred
// BEHAVIOUR
//  - State reg {RUN, MEM_WAIT}; wait counter 8b; mem_err reg. Control outputs combinational from state+inputs.
//  - Reset (rst_n=0): state=RUN, counter=0, mem_err=0; all enables (pc_write,if_id_write,ex_mem_write)=0, all flush/bubble=0.
//  - load_use = id_ex_memread & id_ex_rd!=0 & (id_ex_rd==id_rs | (id_uses_rt & id_ex_rd==id_rt)).
//  - mem_stall = ex_mem_memreq & ~mem_ready.
//  - Priority (high->low): mem_stall, ex_branch_taken, load_use, normal.
//  - RUN, mem_stall: all enables 0, mem_wb_bubble=1, flush/bubble others 0; next=MEM_WAIT, counter=1.
//  - RUN, branch taken: pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_write=1; load_use ignored (wrong path).
//  - RUN, load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; exactly 1 stall cycle per load.
//  - RUN, none: pc_write=if_id_write=ex_mem_write=1, all flush/bubble 0.
//  - MEM_WAIT: outputs as mem_stall case until mem_ready=1 or counter==MEM_TIMEOUT.
//    mem_ready=1 -> RUN same cycle outputs per RUN priority with mem_stall=0 (held branch/load_use applied then); counter=0.
//    counter==MEM_TIMEOUT & ~mem_ready -> mem_err<=1, next=RUN, access treated as complete (MEM/WB gets bubble, pipe advances).
//    else counter+1. Counter saturates; never wraps.
//  - Branch or load_use arriving during MEM_WAIT is held by the frozen pipe and serviced on release; never lost, never doubled.
//  - mem_ready without ex_mem_memreq ignored. mem_err cleared only by reset.
//  - Reset asserted mid MEM_WAIT: immediate return to RUN, counter=0, mem_err=0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: outputs stall_cnt[CNT_W] and flush_cnt[CNT_W]; stall_cnt +1 each cycle pc_write=0,
//   flush_cnt +1 each cycle if_id_flush=1; both saturate at all-ones, reset to 0.
//  Undefined: ports and counters absent; no other behaviour change.
// STRUCTURE
//  Package kgp_hazard_pkg: state enum (RUN, MEM_WAIT), REG_IDX_W=5, ZERO_REG=5'd0, NOP control-word constant.
//  Sub-module mem_wait_timer: saturating counter with start/clear/expired, MEM_TIMEOUT param; FSM and decode in top.
// TESTING
//  Load r5 in EX, ID reads rs=r5 -> 1 cycle pc_write=0,if_id_write=0,id_ex_bubble=1; next cycle all enables 1.
//  Load r0 in EX, ID rs=r0 -> no stall; id_uses_rt=0 with rt match -> no stall.
//  Branch taken + load_use same cycle -> if_id_flush=1,id_ex_bubble=1,pc_write=1; no stall cycle.
//  memreq, mem_ready low 3 cycles -> 3 cycles frozen, mem_wb_bubble=1; release cycle all enables 1, mem_err=0.
//  mem_ready never rises, MEM_TIMEOUT=4 -> freeze 4 cycles, mem_err=1 thereafter, state RUN.
//  rst_n low during MEM_WAIT -> enables 0 asynchronously; after release RUN, mem_err=0; with macro, counters=0.

Source files
------------

// File: rtl/kgp_hazard_pkg.sv
// Shared types and constants for the KGP hazard/stall controller.
// The control word bundles every stage-register enable/bubble so the
// FSM can assign a whole pipeline action in one statement.
package kgp_hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int unsigned REG_IDX_W  = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  // Everything held, nothing bubbled: the word driven while in reset.
  localparam ctrl_t CTRL_NOP    = 6'b000000;
  // Whole pipe frozen behind a pending data access; MEM/WB gets a NOP.
  localparam ctrl_t CTRL_FREEZE = 6'b000001;
  localparam ctrl_t CTRL_ADV    = 6'b110010;
  // IF/ID is written with a NOP, hence write enable stays high with flush.
  localparam ctrl_t CTRL_BRANCH = 6'b111110;
  localparam ctrl_t CTRL_LDUSE  = 6'b000110;

  // Pipeline action when no memory stall is pending. A taken branch wins
  // over load-use because the dependent instruction is on the wrong path.
  function automatic ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
    ctrl_t c;
    if (branch_taken)  c = CTRL_BRANCH;
    else if (load_use) c = CTRL_LDUSE;
    else               c = CTRL_ADV;
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter for a pending data-memory access.
// start loads 1 (the first stalled cycle), clear returns to 0, inc counts
// up and sticks at all-ones. expired_o flags the abort threshold.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, then start, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                          cnt_d = '0;
    else if (start_i)                     cnt_d = CNT_W'(1);
    else if (inc_i && (cnt_q != '1))      cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer for the 5-stage KGP core.
// Optional performance counters (stall_cnt, flush_cnt) exist only when
// HAZARD_PERF_CNT_EN is defined.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | pipe flowing; branch/load-use/mem stall decoded each cycle
//   MEM_WAIT | pipe frozen while the data access in MEM is outstanding
module hazard_stall_ctrl
  import kgp_hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 id_ex_memread,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 ex_mem_memreq,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_write,
  output logic                 mem_wb_bubble,
  output logic                 mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be within 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e state_q, state_d;
  logic   mem_err_q, mem_err_d;
  ctrl_t  ctrl;
  logic   load_use, mem_stall;
  logic   tmr_start, tmr_clear, tmr_inc, tmr_expired;

  assign load_use  = id_ex_memread && (id_ex_rd != ZERO_REG) &&
                     ((id_ex_rd == id_rs) || (id_uses_rt && (id_ex_rd == id_rt)));
  // A ready strobe with no request in MEM is meaningless and drops out here.
  assign mem_stall = ex_mem_memreq && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (WAIT_CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (tmr_start),
    .clear_i   (tmr_clear),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  // Decode the pipeline action and next state from state plus hazards.
  // Branch/load-use seen while frozen are still present on release, since
  // the frozen stage registers keep presenting them.
  always_comb begin
    ctrl      = CTRL_NOP;
    state_d   = state_q;
    mem_err_d = mem_err_q;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    tmr_inc   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl      = CTRL_FREEZE;
          state_d   = MEM_WAIT;
          tmr_start = 1'b1;
        end else begin
          ctrl = run_ctrl(ex_branch_taken, load_use);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          ctrl      = run_ctrl(ex_branch_taken, load_use);
          state_d   = RUN;
          tmr_clear = 1'b1;
        end else if (tmr_expired) begin
          // Abort: treat the access as done, advance, and bubble MEM/WB.
          ctrl               = run_ctrl(ex_branch_taken, load_use);
          ctrl.mem_wb_bubble = 1'b1;
          mem_err_d          = 1'b1;
          state_d            = RUN;
          tmr_clear          = 1'b1;
        end else begin
          ctrl    = CTRL_FREEZE;
          tmr_inc = 1'b1;
        end
      end
      default: begin
        ctrl      = CTRL_NOP;
        state_d   = RUN;
        tmr_clear = 1'b1;
      end
    endcase
    // Outputs must drop the moment reset asserts, not at the next edge.
    if (!rst_n) ctrl = CTRL_NOP;
  end

  // State and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign mem_err       = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters for stalled-PC and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ctrl.if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // No performance counters in this build.
`endif

endmodule
